// File: rtl/ram_bist_pkg.sv
// Shared types, default geometry and the march background pattern for the RAM BIST controller.
`timescale 1ns/1ps
package ram_bist_pkg;

    localparam int         ADDR_W_DEF = 6;
    localparam int         DATA_W_DEF = 8;
    localparam logic [7:0] SEED_DEF   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_UP,
        S_RD_UP,
        S_WR_DN,
        S_RD_DN,
        S_DONE
    } bist_state_t;

    // Computed at 32 bits so callers with any ADDR_W/DATA_W can truncate to their own width.
    function automatic logic [31:0] bist_pattern(input logic [31:0] seed,
                                                 input logic [31:0] a,
                                                 input logic        inv);
        logic [31:0] p;
        p = seed ^ a;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-compare pipeline: holds the expected data for the read in flight, counts mismatches and
// captures where the first one happened.
`timescale 1ns/1ps
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DATA_W-1:0] iss_exp,
    input  logic              iss_phase,
    input  logic [DATA_W-1:0] dout,
    output logic [7:0]        fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              first_fail_phase,
    output logic              any_fail_next
);

    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_exp;
    logic              cmp_phase;
    logic              hit;

    assign hit           = cmp_valid && (dout != cmp_exp);
    // Lets the FSM fold the compare landing on its final edge into the pass verdict.
    assign any_fail_next = hit || (fail_count != 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_valid        <= 1'b0;
            cmp_addr         <= '0;
            cmp_exp          <= '0;
            cmp_phase        <= 1'b0;
            fail_count       <= 8'd0;
            first_fail_addr  <= '0;
            first_fail_phase <= 1'b0;
        end else if (clear) begin
            cmp_valid        <= 1'b0;
            cmp_addr         <= '0;
            cmp_exp          <= '0;
            cmp_phase        <= 1'b0;
            fail_count       <= 8'd0;
            first_fail_addr  <= '0;
            first_fail_phase <= 1'b0;
        end else begin
            cmp_valid <= iss_valid;
            cmp_addr  <= iss_addr;
            cmp_exp   <= iss_exp;
            cmp_phase <= iss_phase;
            if (hit) begin
                if (fail_count != 8'hFF)
                    fail_count <= fail_count + 8'd1;
                if (fail_count == 8'd0) begin
                    first_fail_addr  <= cmp_addr;
                    first_fail_phase <= cmp_phase;
                end
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// Four-pass march BIST sequencer driving the 64x8 RAM; all RAM-facing outputs are posedge
// registers so they are stable across the RAM's negedge sample.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   S_IDLE  | waiting for start after reset
//   S_WR_UP | writing P(a), a ascending
//   S_RD_UP | reading, expecting P(a), a ascending
//   S_WR_DN | writing ~P(a), a descending
//   S_RD_DN | reading, expecting ~P(a), a descending
//   S_DONE  | results held until next start or reset
`timescale 1ns/1ps
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(SEED_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              first_fail_phase,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    bist_state_t       state;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_dec;
    logic              launch;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_exp;
    logic              iss_phase;
    logic              any_fail_next;

    assign addr_inc = addr + 1'b1;
    assign addr_dec = addr - 1'b1;
    assign launch   = start && ((state == S_IDLE) || (state == S_DONE));

    // Mirrors the FSM's next read so its expected data is registered on the same edge the read issues.
    always_comb begin
        iss_valid = 1'b0;
        iss_addr  = '0;
        iss_phase = 1'b0;
        case (state)
            S_WR_UP: if (addr == ADDR_LAST) iss_valid = 1'b1;
            S_RD_UP: if (addr != ADDR_LAST) begin
                iss_valid = 1'b1;
                iss_addr  = addr_inc;
            end
            S_WR_DN: if (addr == '0) begin
                iss_valid = 1'b1;
                iss_addr  = ADDR_LAST;
                iss_phase = 1'b1;
            end
            S_RD_DN: if (addr != '0) begin
                iss_valid = 1'b1;
                iss_addr  = addr_dec;
                iss_phase = 1'b1;
            end
            default: ;
        endcase
        iss_exp = DATA_W'(bist_pattern(32'(SEED), 32'(iss_addr), iss_phase));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            rw    <= 1'b0;
            addr  <= '0;
            din   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_WR_UP;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        rw    <= 1'b1;
                        addr  <= '0;
                        din   <= DATA_W'(bist_pattern(32'(SEED), 32'd0, 1'b0));
                    end
                end
                S_WR_UP: begin
                    if (addr == ADDR_LAST) begin
                        state <= S_RD_UP;
                        rw    <= 1'b0;
                        addr  <= '0;
                        din   <= '0;
                    end else begin
                        addr <= addr_inc;
                        din  <= DATA_W'(bist_pattern(32'(SEED), 32'(addr_inc), 1'b0));
                    end
                end
                S_RD_UP: begin
                    if (addr == ADDR_LAST) begin
                        state <= S_WR_DN;
                        rw    <= 1'b1;
                        din   <= DATA_W'(bist_pattern(32'(SEED), 32'(ADDR_LAST), 1'b1));
                    end else begin
                        addr <= addr_inc;
                    end
                end
                S_WR_DN: begin
                    if (addr == '0) begin
                        state <= S_RD_DN;
                        rw    <= 1'b0;
                        addr  <= ADDR_LAST;
                        din   <= '0;
                    end else begin
                        addr <= addr_dec;
                        din  <= DATA_W'(bist_pattern(32'(SEED), 32'(addr_dec), 1'b1));
                    end
                end
                S_RD_DN: begin
                    if (addr == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !any_fail_next;
                    end else begin
                        addr <= addr_dec;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    rw    <= 1'b0;
                    addr  <= '0;
                    din   <= '0;
                end
            endcase
        end
    end

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk              (clk),
        .reset            (reset),
        .clear            (launch),
        .iss_valid        (iss_valid),
        .iss_addr         (iss_addr),
        .iss_exp          (iss_exp),
        .iss_phase        (iss_phase),
        .dout             (dout),
        .fail_count       (fail_count),
        .first_fail_addr  (first_fail_addr),
        .first_fail_phase (first_fail_phase),
        .any_fail_next    (any_fail_next)
    );

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test sequencer that sits directly upstream of the 64x8 RAM.
- Drives the RAM's rw/addr/din and consumes its dout, replacing the fixed two-address exerciser FSM.
- Runs a four-pass march (write up, read up, write inverted down, read inverted down) over every location.
- Reports pass/fail, mismatch count and the first failing location to the system.

Parameters:
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- SEED, 8'hA5, background pattern XORed with the address.

Ports:
- clk  in  1  clock; all controller state on posedge.
- reset  in  1  asynchronous, active-low.
- start  in  1  single-cycle request; honoured only in IDLE or DONE.
- busy  out  1  high while a march is running.
- done  out  1  high from march completion until next start or reset.
- pass  out  1  valid while done; 1 = zero mismatches.
- fail_count  out  8  mismatch count, saturates at 255.
- first_fail_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- first_fail_phase  out  1  0 = read-up pass, 1 = read-down pass.
- rw  out  1  to RAM; 1 = write, 0 = read.
- addr  out  ADDR_W  to RAM.
- din  out  DATA_W  to RAM write data.
- dout  in  DATA_W  from RAM read data.

Behaviour:
- Reset (async, active-low) forces IDLE.
- Reset values: busy=0, done=0, pass=0, fail_count=0, first_fail_addr=0, first_fail_phase=0, rw=0, addr=0, din=0.
- All RAM-facing outputs are posedge registers. The RAM samples on negedge, so outputs must be stable across the negedge. No combinational paths from state to rw/addr/din.
- Pattern: P(a) = SEED ^ zero-extended a. Inverted pattern: ~P(a).
- States: IDLE, WR_UP, RD_UP, WR_DN, RD_DN, DONE.
- IDLE/DONE, start=1 sampled at posedge S:
  - clear done/pass/fail_count/first_fail_*; busy=1.
  - enter WR_UP with rw=1, addr=0, din=P(0) all set at S.
- WR_UP: one write per cycle, addr 0..63, din=P(addr). After addr 63, go to RD_UP, addr=0.
- RD_UP: rw=0, addr 0..63. After 63, go to WR_DN, addr=63.
- WR_DN: rw=1, addr 63..0, din=~P(addr). After 0, go to RD_DN, addr=63.
- RD_DN: rw=0, addr 63..0. After 0, go to DONE.
- Read pipeline:
  - A read issued at posedge k returns dout after negedge k. The compare executes at posedge k+1 against expected data registered at posedge k, held in cmp_valid/cmp_addr/cmp_exp/cmp_phase.
  - The last RD_UP compare lands on the first WR_DN posedge. This is legal: the RAM holds dout during writes.
- Mismatch:
  - fail_count increments, saturating at 255.
  - On the first mismatch only, capture first_fail_addr and first_fail_phase.
- Completion:
  - At posedge S+256, the last compare executes; state becomes DONE, busy=0, done=1.
  - pass = 1 iff no mismatch, including that final compare.
  - Total latency from start sample to done is 256 cycles.
- DONE: rw=0, addr=0, din=0; results held.
- start while busy is ignored.
- start and reset together: reset wins.
- Reset mid-march: immediate return to IDLE, results cleared, in-flight compare discarded.
- RAM contents after an abort are undefined.
- Address counter wraps only at the pass boundary; no other wrap.

Decomposition:
- Package ram_bist_pkg contains:
  - state enum.
  - ADDR_W/DATA_W/SEED defaults.
  - pattern function P(a, inv).
- Sub-module ram_bist_cmp holds the compare pipeline register, saturating fail_count and first-fail capture.
- Top holds the FSM and address counter.

Test Plan:
- Good RAM: reset low 10 ns, release, pulse start -> busy 256 cycles; done=1, pass=1, fail_count=0. RAM[35]=8'h86 and RAM[39]=8'h82 after WR_UP; final RAM[35]=8'h79.
- Stuck bit: bench forces dout[0]^=1 whenever addr==35 and rw=0 -> fail_count=2, first_fail_addr=35, first_fail_phase=0, pass=0.
- Corruption between passes: hierarchically overwrite ram[39]=8'h00 after WR_DN completes -> fail_count=1, first_fail_addr=39, first_fail_phase=1.
- Reset at cycle 100 of march -> all outputs return to reset values asynchronously. A new start then completes in 256 cycles with pass=1.
- start pulsed mid-march at cycle 50 -> ignored, done still at cycle 256. start in DONE -> results cleared, second march runs.
- Timing check: assert rw/addr/din never change within ±1 ns of any negedge clk for the whole run.
